axi_burst_addr_gen: RTL and testbench

AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

---
 rtl/axi_burst_addr_gen.sv | 134 +++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_addr_gen.sv
// AXI burst beat-address generator: FIXED / INCR bursts, optional WRAP.
// Define WRAP_BURST_EN to build WRAP support; otherwise WRAP commands are rejected.
module axi_burst_addr_gen #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int LEN_WIDTH      = 8,
    parameter int MAX_SIZE       = 3
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      run,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
    input  logic [LEN_WIDTH-1:0]      i_len,
    input  logic [2:0]                i_size,
    input  logic [1:0]                i_burst,
    output logic                      o_addr_valid,
    input  logic                      i_addr_ready,
    output logic [AXI_ADDR_WIDTH-1:0] o_addr,
    output logic                      o_last,
    output logic                      o_err
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                    state;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      beat_cnt;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;

    logic                      cmd_legal;
    logic [AXI_ADDR_WIDTH-1:0] in_mask;
    logic [AXI_ADDR_WIDTH-1:0] step;
    logic [AXI_ADDR_WIDTH-1:0] size_mask;
    logic [AXI_ADDR_WIDTH-1:0] next_addr;
`ifdef WRAP_BURST_EN
    logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
`endif

    assign o_cmd_ready = arst_n && run && (state == IDLE);

    always_comb begin
        in_mask   = (AXI_ADDR_WIDTH'(1) << i_size) - AXI_ADDR_WIDTH'(1);
        cmd_legal = 1'b1;
        if (i_burst == 2'b11) cmd_legal = 1'b0;
        if (int'(i_size) > MAX_SIZE) cmd_legal = 1'b0;
        if (i_burst == 2'b10) begin
`ifdef WRAP_BURST_EN
            if (!(i_len == LEN_WIDTH'(1) || i_len == LEN_WIDTH'(3) ||
                  i_len == LEN_WIDTH'(7) || i_len == LEN_WIDTH'(15)))
                cmd_legal = 1'b0;
            if ((i_addr & in_mask) != '0) cmd_legal = 1'b0;
`else
            cmd_legal = 1'b0;
`endif
        end
    end

    always_comb begin
        step      = AXI_ADDR_WIDTH'(1) << size_q;
        size_mask = step - AXI_ADDR_WIDTH'(1);
`ifdef WRAP_BURST_EN
        wrap_mask = ((AXI_ADDR_WIDTH'(len_q) + AXI_ADDR_WIDTH'(1)) << size_q)
                    - AXI_ADDR_WIDTH'(1);
`endif
        case (burst_q)
            2'b01:   next_addr = (o_addr & ~size_mask) + step;
`ifdef WRAP_BURST_EN
            2'b10:   next_addr = (o_addr & ~wrap_mask) | ((o_addr + step) & wrap_mask);
`endif
            default: next_addr = o_addr;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= IDLE;
            len_q        <= '0;
            beat_cnt     <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            o_addr_valid <= 1'b0;
            o_addr       <= '0;
            o_last       <= 1'b0;
            o_err        <= 1'b0;
        end else if (!run) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            o_addr_valid <= 1'b0;
            o_last       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Illegal commands are still handshaken, then flagged.
                    if (i_cmd_valid) begin
                        if (cmd_legal) begin
                            state        <= BURST;
                            len_q        <= i_len;
                            size_q       <= i_size;
                            burst_q      <= i_burst;
                            beat_cnt     <= '0;
                            o_addr_valid <= 1'b1;
                            o_addr       <= i_addr;
                            o_last       <= (i_len == '0);
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (i_addr_ready) begin
                        if (o_last) begin
                            state        <= IDLE;
                            o_addr_valid <= 1'b0;
                            o_last       <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            o_addr   <= next_addr;
                            o_last   <= ((beat_cnt + 1'b1) == len_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: vector table, hand sequences, random vs model.
module tb_axi_burst_addr_gen;

    localparam int AW = 64;
    localparam int LW = 8;
    localparam int MS = 3;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          run;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_len;
    logic [2:0]    i_size;
    logic [1:0]    i_burst;
    logic          o_addr_valid;
    logic          i_addr_ready;
    logic [AW-1:0] o_addr;
    logic          o_last;
    logic          o_err;

    axi_burst_addr_gen #(
        .AXI_ADDR_WIDTH(AW),
        .LEN_WIDTH     (LW),
        .MAX_SIZE      (MS)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .run         (run),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_addr      (i_addr),
        .i_len       (i_len),
        .i_size      (i_size),
        .i_burst     (i_burst),
        .o_addr_valid(o_addr_valid),
        .i_addr_ready(i_addr_ready),
        .o_addr      (o_addr),
        .o_last      (o_last),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] q_addr[$];
    logic          q_last[$];

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
        int            size;
        int            burst;
        int            mode;
        bit            exp_err;
        int            exp_n;
        logic [AW-1:0] exp_a[4];
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [AW-1:0] a, input int len, input int size,
                                 input int burst, input int mode, input bit e, input int n,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        vec_t v;
        v.addr = a; v.len = len; v.size = size; v.burst = burst; v.mode = mode;
        v.exp_err = e; v.exp_n = n;
        v.exp_a[0] = a0; v.exp_a[1] = a1; v.exp_a[2] = a2; v.exp_a[3] = a3;
        return v;
    endfunction

    function automatic bit ref_legal(input logic [AW-1:0] a, input int len, input int size,
                                     input int burst);
        if (burst == 3) return 1'b0;
        if (size > MS) return 1'b0;
        if (burst == 2) begin
`ifdef WRAP_BURST_EN
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
            if (a % (64'd1 << size) != 0) return 1'b0;
`else
            return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    // Address of beat n computed directly from the start address.
    function automatic logic [AW-1:0] ref_beat(input logic [AW-1:0] a, input int len,
                                               input int size, input int burst, input int n);
        logic [AW-1:0] stp, blk, base;
        stp = 64'd1 << size;
        if (burst == 0 || n == 0) return a;
        if (burst == 1) return (a - a % stp) + stp * 64'(n);
        blk  = stp * 64'(len + 1);
        base = a - a % blk;
        return base + ((a - base + stp * 64'(n)) % blk);
    endfunction

    // mode 0: ready always high, 1: toggling 1/0, 2: random
    task automatic do_cmd(input logic [AW-1:0] a, input int len, input int size,
                          input int burst, input int mode, input string tag,
                          output logic got_err);
        int   wait_c;
        int   cyc;
        bit   legal;
        bit   stall;
        bit   rdy;
        bit   done;
        logic [AW-1:0] held_a;
        logic held_l;
        q_addr.delete();
        q_last.delete();
        got_err = 1'b0;
        @(negedge clk);
        i_addr = a; i_len = len[LW-1:0]; i_size = size[2:0]; i_burst = burst[1:0];
        i_cmd_valid = 1'b1;
        wait_c = 0;
        while (!o_cmd_ready && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        if (!o_cmd_ready) begin
            chk({tag, " cmd_ready timeout"}, 0, 1);
            i_cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        i_cmd_valid = 1'b0;
        got_err = o_err;
        legal = ref_legal(a, len, size, burst);
        chk({tag, " err"}, o_err, !legal);
        if (!legal) begin
            chk({tag, " no beat after illegal"}, o_addr_valid, 0);
            @(negedge clk);
            chk({tag, " err pulse width"}, o_err, 0);
            chk({tag, " still no beat"}, o_addr_valid, 0);
            return;
        end
        stall = 1'b0;
        done  = 1'b0;
        cyc   = 0;
        held_a = '0;
        held_l = 1'b0;
        while (cyc < 400 && !done) begin
            if (stall) begin
                chk({tag, " stall valid"}, o_addr_valid, 1);
                chk({tag, " stall addr"}, o_addr, held_a);
                chk({tag, " stall last"}, o_last, held_l);
            end
            if (!o_addr_valid) break;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_addr_ready = rdy;
            if (rdy) begin
                q_addr.push_back(o_addr);
                q_last.push_back(o_last);
                stall = 1'b0;
                done  = o_last;
            end else begin
                stall  = 1'b1;
                held_a = o_addr;
                held_l = o_last;
            end
            @(negedge clk);
            cyc++;
        end
        i_addr_ready = 1'b0;
        if (done) begin
            chk({tag, " valid drops after last"}, o_addr_valid, 0);
            chk({tag, " ready after last"}, o_cmd_ready, 1);
        end
        chk({tag, " beat count"}, 64'(q_addr.size()), 64'(len + 1));
        for (int i = 0; i < q_addr.size() && i <= len; i++) begin
            chk($sformatf("%s beat%0d addr", tag, i), q_addr[i], ref_beat(a, len, size, burst, i));
            chk($sformatf("%s beat%0d last", tag, i), q_last[i], (i == len));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic          e;
        logic [AW-1:0] ra;
        int            rl, rs, rb, rm;
        int            wl[4];

        vecs[0] = mkv(64'h1000, 3, 2, 1, 0, 0, 4, 64'h1000, 64'h1004, 64'h1008, 64'h100C);
        vecs[1] = mkv(64'h1003, 2, 2, 1, 0, 0, 3, 64'h1003, 64'h1004, 64'h1008, 64'h0);
`ifdef WRAP_BURST_EN
        vecs[2] = mkv(64'h38, 3, 3, 2, 0, 0, 4, 64'h38, 64'h20, 64'h28, 64'h30);
        vecs[10] = mkv(64'h14, 1, 2, 2, 2, 0, 2, 64'h14, 64'h10, 64'h0, 64'h0);
`else
        vecs[2] = mkv(64'h38, 3, 3, 2, 0, 1, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[10] = mkv(64'h14, 1, 2, 2, 2, 1, 0, 64'h0, 64'h0, 64'h0, 64'h0);
`endif
        vecs[3] = mkv(64'h40, 2, 2, 0, 1, 0, 3, 64'h40, 64'h40, 64'h40, 64'h0);
        vecs[4] = mkv(64'h100, 1, 2, 3, 0, 1, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[5] = mkv(64'h40, 2, 2, 2, 0, 1, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[6] = mkv(64'h77, 0, 0, 1, 0, 0, 1, 64'h77, 64'h0, 64'h0, 64'h0);
        vecs[7] = mkv(64'h80, 1, 4, 1, 0, 1, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[8] = mkv(64'h3C, 3, 3, 2, 0, 1, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        vecs[9] = mkv(64'hFFFF_FFFF_FFFF_FFF8, 2, 3, 1, 2, 0, 3,
                      64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8, 64'h0);

        arst_n = 1'b0; run = 1'b0; i_cmd_valid = 1'b0; i_addr = '0; i_len = '0;
        i_size = '0; i_burst = '0; i_addr_ready = 1'b0;
        run = 1'b1;
        #1;
        chk("reset cmd_ready", o_cmd_ready, 0);
        chk("reset addr_valid", o_addr_valid, 0);
        chk("reset last", o_last, 0);
        chk("reset err", o_err, 0);
        chk("reset addr", o_addr, 0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("idle cmd_ready", o_cmd_ready, 1);

        for (int k = 0; k < 11; k++) begin
            do_cmd(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].mode,
                   $sformatf("vec%0d", k), e);
            chk($sformatf("vec%0d table err", k), e, vecs[k].exp_err);
            chk($sformatf("vec%0d table beats", k), 64'(q_addr.size()), 64'(vecs[k].exp_n));
            for (int i = 0; i < vecs[k].exp_n && i < q_addr.size(); i++)
                chk($sformatf("vec%0d table beat%0d", k, i), q_addr[i], vecs[k].exp_a[i]);
        end

        // run low after the second beat handshake of a len=7 INCR burst
        @(negedge clk);
        i_addr = 64'h2000; i_len = 8'd7; i_size = 3'd2; i_burst = 2'b01; i_cmd_valid = 1'b1;
        chk("abort cmd_ready", o_cmd_ready, 1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_addr_ready = 1'b1;
        chk("abort beat0", o_addr, 64'h2000);
        @(negedge clk);
        chk("abort beat1", o_addr, 64'h2004);
        @(negedge clk);
        chk("abort beat2", o_addr, 64'h2008);
        chk("abort no ready in burst", o_cmd_ready, 0);
        run = 1'b0;
        @(negedge clk);
        chk("abort valid", o_addr_valid, 0);
        chk("abort err", o_err, 0);
        chk("abort cmd_ready while run low", o_cmd_ready, 0);
        run = 1'b1;
        i_addr_ready = 1'b0;
        @(negedge clk);
        chk("abort back to idle", o_cmd_ready, 1);
        chk("abort still no valid", o_addr_valid, 0);
        do_cmd(64'h2100, 1, 2, 1, 0, "post-abort", e);

        // asynchronous reset in the middle of a stalled burst
        @(negedge clk);
        i_addr = 64'h3000; i_len = 8'd7; i_size = 3'd3; i_burst = 2'b01; i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        chk("arst pre valid", o_addr_valid, 1);
        chk("arst pre addr", o_addr, 64'h3000);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst valid", o_addr_valid, 0);
        chk("arst last", o_last, 0);
        chk("arst err", o_err, 0);
        chk("arst addr", o_addr, 0);
        chk("arst cmd_ready", o_cmd_ready, 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("post-arst ready", o_cmd_ready, 1);
        chk("post-arst valid", o_addr_valid, 0);
        do_cmd(64'h3100, 2, 1, 1, 0, "post-arst", e);

        wl[0] = 1; wl[1] = 3; wl[2] = 7; wl[3] = 15;
        for (int n = 0; n < 60; n++) begin
            rb = $urandom_range(0, 3);
            rs = ($urandom_range(0, 9) == 0) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
            if (rb == 2 && $urandom_range(0, 4) != 0) rl = wl[$urandom_range(0, 3)];
            else rl = $urandom_range(0, 15);
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra[63:12] = '1;
            if (rb == 2 && rs <= MS && $urandom_range(0, 4) != 0)
                ra = ra & ~((64'd1 << rs) - 64'd1);
            rm = $urandom_range(0, 2);
            do_cmd(ra, rl, rs, rb, rm, $sformatf("rnd%0d", n), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
